aes_key_sched: RTL and testbench

Unified AES key scheduler that expands a 128-, 192- or 256-bit cipher key, selected at run time, into Nr+1 round keys. It streams the round keys to the round datapath over a valid/ready handshake, in forward order for encryption or reverse order for decryption. It keeps the last expanded schedule so it can be replayed without being recomputed. It replaces the fixed-width expanders in the cipher cores.

---
 rtl/aes_key_sched.sv | 260 ++++++++++++++++++++++++++
 tb/tb_aes_key_sched.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched.sv
// aes_key_sched: run-time 128/192/256-bit AES key expander streaming
// round keys forward, reversed or replayed from a round-key store.
module aes_key_sched #(
  parameter int MAX_NK = 8,
  parameter bit REV_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   keylen,
  input  logic         reverse,
  input  logic         replay,
  input  logic [255:0] key,
  output logic         busy,
  output logic         err,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_idx,
  output logic         rk_last
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GEN   = 2'd1;
  localparam logic [1:0] FILL  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [10:0] b;
    b = 11'd2040 - {x, 3'b000};
    return SBOX[b +: 8];
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  logic [1:0]       state;
  logic [3:0]       k;
  logic [1:0]       klen;
  logic             rev;
  logic [0:7][31:0] win;
  logic [2:0]       phase;
  logic [7:0]       rcon;
  logic [127:0]     store [16];
  logic             stored_ok;
  logic [1:0]       stored_len;

  logic [3:0]  nr;
  logic [3:0]  nr_in;
  logic [3:0]  nk_in;
  logic        bad;
  logic        go;
  logic        hs;
  logic        adv;
  logic        wr;
  logic        sp;
  logic        lane2;
  logic        rot;
  logic [31:0] wlast;
  logic [31:0] p1;
  logic [31:0] sb_in;
  logic [31:0] tsp;
  logic [31:0] n0;
  logic [31:0] n1;
  logic [31:0] n2;
  logic [31:0] n3;

  // request decode: key length, round count and rejection rules
  always_comb begin
    nk_in = 4'd0;
    nr_in = 4'd0;
    unique case (keylen)
      2'd0: begin nk_in = 4'd4; nr_in = 4'd10; end
      2'd1: begin nk_in = 4'd6; nr_in = 4'd12; end
      2'd2: begin nk_in = 4'd8; nr_in = 4'd14; end
      default: ;
    endcase
    bad = (keylen == 2'd3)
        || (int'(nk_in) > MAX_NK)
        || (!REV_EN && (reverse || replay))
        || (replay && !stored_ok)
        || (replay && (keylen != stored_len));
    go = (state == IDLE) && start && !bad;
  end

  // one expansion step: 4 new words, single SubWord unit on the special lane
  always_comb begin
    sp    = 1'b1;
    lane2 = 1'b0;
    rot   = 1'b1;
    wlast = win[3];
    nr    = 4'd10;
    unique case (klen)
      2'd1: begin
        wlast = win[5];
        nr    = 4'd12;
        sp    = (phase != 3'd2);
        lane2 = (phase == 3'd4);
      end
      2'd2: begin
        wlast = win[7];
        nr    = 4'd14;
        rot   = (phase == 3'd0);
      end
      default: ;
    endcase
    p1    = win[1] ^ win[0] ^ wlast;
    sb_in = lane2 ? p1 : wlast;
    if (rot) sb_in = {sb_in[23:0], sb_in[31:24]};
    tsp = subword(sb_in) ^ {(rot ? rcon : 8'h00), 24'h0};
    n0  = win[0] ^ ((sp && !lane2) ? tsp : wlast);
    n1  = win[1] ^ n0;
    n2  = win[2] ^ ((sp && lane2) ? tsp : n1);
    n3  = win[3] ^ n2;
  end

  // output stream: live window in GEN, stored schedule in DRAIN
  always_comb begin
    rk = '0;
    unique case (state)
      GEN:     rk = {win[0], win[1], win[2], win[3]};
      DRAIN:   rk = REV_EN ? store[k] : '0;
      default: ;
    endcase
    busy     = (state != IDLE);
    rk_valid = (state == GEN) || (state == DRAIN);
    rk_idx   = rk_valid ? k : 4'd0;
    rk_last  = rk_valid && (rev ? (k == 4'd0) : (k == nr));
    hs       = rk_valid && rk_ready;
    adv      = ((state == GEN) && hs && (k != nr))
            || ((state == FILL) && (k != nr));
    wr       = ((state == GEN) && hs) || (state == FILL);
  end

  // control FSM, round counter and stored-schedule bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      k          <= 4'd0;
      klen       <= 2'd0;
      rev        <= 1'b0;
      stored_ok  <= 1'b0;
      stored_len <= 2'd0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          if (bad) begin
            err <= 1'b1;
          end else begin
            klen <= keylen;
            rev  <= reverse;
            k    <= (replay && reverse) ? nr_in : 4'd0;
            if (replay) begin
              state <= DRAIN;
            end else begin
              stored_ok  <= 1'b0;
              stored_len <= keylen;
              state      <= reverse ? FILL : GEN;
            end
          end
        end
        GEN: if (hs) begin
          if (k == nr) begin
            stored_ok <= 1'b1;
            state     <= IDLE;
          end else begin
            k <= k + 4'd1;
          end
        end
        FILL: begin
          if (k == nr) begin
            stored_ok <= 1'b1;
            state     <= DRAIN;
          end else begin
            k <= k + 4'd1;
          end
        end
        DRAIN: if (hs) begin
          if (rk_last) state <= IDLE;
          else if (rev) k <= k - 4'd1;
          else k <= k + 4'd1;
        end
      endcase
    end
  end

  // expansion window: load key at start, slide by 4 words per step
  always_ff @(posedge clk) begin
    if (reset) begin
      win   <= '0;
      phase <= 3'd0;
      rcon  <= 8'h01;
    end else if (go && !replay) begin
      win   <= key;
      phase <= 3'd0;
      rcon  <= 8'h01;
    end else if (adv) begin
      unique case (klen)
        2'd1: begin
          win[0] <= win[4];
          win[1] <= win[5];
          win[2] <= n0;
          win[3] <= n1;
          win[4] <= n2;
          win[5] <= n3;
          phase  <= (phase == 3'd0) ? 3'd4 :
                    (phase == 3'd4) ? 3'd2 : 3'd0;
        end
        2'd2: begin
          win[0] <= win[4];
          win[1] <= win[5];
          win[2] <= win[6];
          win[3] <= win[7];
          win[4] <= n0;
          win[5] <= n1;
          win[6] <= n2;
          win[7] <= n3;
          phase  <= phase ^ 3'd4;
        end
        default: begin
          win[0] <= n0;
          win[1] <= n1;
          win[2] <= n2;
          win[3] <= n3;
          phase  <= 3'd0;
        end
      endcase
      if (sp && rot)
        rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    end
  end

  // round-key store written as keys are produced
  always_ff @(posedge clk) begin
    if (REV_EN && wr) store[k] <= {win[0], win[1], win[2], win[3]};
  end

endmodule

// File: tb/tb_aes_key_sched.sv
// tb_aes_key_sched: round-key streams against a word-level expansion model
// plus FIPS-197 vectors and handshake corner cases.
module tb_aes_key_sched;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   keylen = 2'd0;
  logic         reverse = 1'b0;
  logic         replay = 1'b0;
  logic [255:0] key = '0;
  logic         rk_ready = 1'b0;
  logic         busy;
  logic         err;
  logic         rk_valid;
  logic [127:0] rk;
  logic [3:0]   rk_idx;
  logic         rk_last;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] mdl [15];
  logic [127:0] got_rk [15];
  logic [3:0]   got_idx [15];
  logic         got_last [15];

  typedef struct {
    logic [1:0]   kl;
    bit           rv;
    bit           rnd;
    logic [255:0] key;
    int           ia;
    logic [127:0] ea;
    int           ib;
    logic [127:0] eb;
  } vec_t;

  vec_t vecs [3];

  aes_key_sched dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .keylen(keylen),
    .reverse(reverse),
    .replay(replay),
    .key(key),
    .busy(busy),
    .err(err),
    .rk_valid(rk_valid),
    .rk_ready(rk_ready),
    .rk(rk),
    .rk_idx(rk_idx),
    .rk_last(rk_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [135:0] act,
                     input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] r3;
    logic [7:0] r4;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      r1 = {inv[6:0], inv[7]};
      r2 = {r1[6:0], r1[7]};
      r3 = {r2[6:0], r2[7]};
      r4 = {r3[6:0], r3[7]};
      sbox_t[a] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
    return r;
  endfunction

  // full word-list expansion, then grouped into round keys
  task automatic model(input logic [1:0] kl, input logic [255:0] kk);
    int nk;
    int nr;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [255:0] sh;
    logic [7:0] rc;
    nk = 4 + 2 * int'(kl);
    nr = nk + 6;
    for (int i = 0; i < nk; i++) begin
      sh = kk << (32 * i);
      w[i] = sh[255:224];
    end
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        rc = 8'h01;
        for (int j = 1; j < i / nk; j++) rc = gmul(rc, 8'h02);
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      end else if (nk == 8 && i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++)
      mdl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // one-cycle start strobe; inputs are scrambled afterwards
  task automatic req(input logic [1:0] kl, input bit rv, input bit rp,
                     input logic [255:0] kk);
    keylen  = kl;
    reverse = rv;
    replay  = rp;
    key     = kk;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    keylen  = 2'($urandom_range(0, 3));
    reverse = ~rv;
    replay  = 1'($urandom_range(0, 1));
    key     = rnd256();
  endtask

  task automatic run(input int nr, input bit rv, input bit rnd,
                     input int exp_lat, input string nm);
    int n = 0;
    int first = -1;
    int lastc = -1;
    int e;
    bit stall = 1'b0;
    bit rdy;
    logic [127:0] prk = '0;
    logic [3:0] pidx = '0;
    logic plast = 1'b0;
    for (int c = 1; c <= 400 && n <= nr; c++) begin
      if (c > 1) @(negedge clk);
      if (stall)
        chk({nm, " stall"}, {rk_valid, rk_last, rk_idx, rk},
            {1'b1, plast, pidx, prk});
      if (rk_valid && first < 0) begin
        first = c;
        chk({nm, " latency"}, 136'(c), 136'(exp_lat));
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      rk_ready = rdy;
      stall = rk_valid && !rdy;
      prk = rk;
      pidx = rk_idx;
      plast = rk_last;
      if (rk_valid && rdy) begin
        got_rk[n] = rk;
        got_idx[n] = rk_idx;
        got_last[n] = rk_last;
        n++;
        lastc = c;
      end
    end
    if (n <= nr) begin
      chk({nm, " timeout"}, 136'(n), 136'(nr + 1));
      rk_ready = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      return;
    end
    if (!rnd) chk({nm, " back-to-back"}, 136'(lastc - first), 136'(nr));
    for (int i = 0; i <= nr; i++) begin
      e = rv ? nr - i : i;
      chk($sformatf("%s key%0d", nm, i),
          {2'b00, got_last[i], got_idx[i], got_rk[i]},
          {2'b00, 1'(i == nr), 4'(e), mdl[e]});
    end
    @(negedge clk);
    chk({nm, " idle after"}, 136'({busy, rk_valid}), 136'(0));
    rk_ready = 1'b0;
  endtask

  task automatic expect_err(input logic [1:0] kl, input bit rv, input bit rp,
                            input string nm);
    req(kl, rv, rp, rnd256());
    chk({nm, " err"}, 136'({err, busy, rk_valid}), 136'(3'b100));
    @(negedge clk);
    chk({nm, " err clr"}, 136'({err, busy, rk_valid}), 136'(3'b000));
  endtask

  initial begin
    int nr;
    int pos;
    bit found;
    logic [1:0] kl;
    logic [1:0] last_kl;
    bit rv;
    bit rnd;
    logic [255:0] kk;

    build_sbox();
    vecs[0] = '{2'd0, 1'b0, 1'b0,
                {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                1, 128'ha0fafe1788542cb123a339392a6c7605,
                10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{2'd1, 1'b1, 1'b0,
                {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0},
                12, 128'he98ba06f448c773c8ecc720401002202,
                0, 128'h8e73b0f7da0e6452c810f32b809079e5};
    vecs[2] = '{2'd2, 1'b0, 1'b1,
                256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                1, 128'h1f352c073b6108d72d9810a30914dff4,
                14, 128'hfe4890d1e6188d0b046df344706c631e};

    repeat (3) @(negedge clk);
    chk("reset state", {7'b0, busy, err, rk_valid, rk_last, rk_idx, rk}, '0);
    reset = 1'b0;
    @(negedge clk);

    expect_err(2'd0, 1'b0, 1'b1, "replay after reset");
    expect_err(2'd3, 1'b0, 1'b0, "keylen 11");

    for (int v = 0; v < 3; v++) begin
      nr = 10 + 2 * int'(vecs[v].kl);
      model(vecs[v].kl, vecs[v].key);
      req(vecs[v].kl, vecs[v].rv, 1'b0, vecs[v].key);
      run(nr, vecs[v].rv, vecs[v].rnd, vecs[v].rv ? nr + 2 : 1,
          $sformatf("vec%0d", v));
      pos = vecs[v].rv ? nr - vecs[v].ia : vecs[v].ia;
      chk($sformatf("vec%0d fips idx%0d", v, vecs[v].ia),
          136'(got_rk[pos]), 136'(vecs[v].ea));
      pos = vecs[v].rv ? nr - vecs[v].ib : vecs[v].ib;
      chk($sformatf("vec%0d fips idx%0d", v, vecs[v].ib),
          136'(got_rk[pos]), 136'(vecs[v].eb));
    end

    req(2'd2, 1'b1, 1'b1, rnd256());
    run(14, 1'b1, 1'b0, 1, "replay256 rev");
    expect_err(2'd0, 1'b0, 1'b1, "replay len mismatch");
    chk("no keys after reject", 136'({rk_valid, busy}), 136'(0));

    kk = rnd256();
    model(2'd0, kk);
    req(2'd0, 1'b0, 1'b0, kk);
    keylen = 2'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start while busy", 136'({err, rk_valid, rk_idx}), 136'(6'b010000));
    run(10, 1'b0, 1'b0, 1, "after busy start");

    last_kl = 2'd0;
    for (int r = 0; r < 12; r++) begin
      kl = 2'($urandom_range(0, 2));
      rv = 1'($urandom_range(0, 1));
      rnd = 1'($urandom_range(0, 1));
      kk = rnd256();
      nr = 10 + 2 * int'(kl);
      model(kl, kk);
      req(kl, rv, 1'b0, kk);
      run(nr, rv, rnd, rv ? nr + 2 : 1, $sformatf("rnd%0d", r));
      last_kl = kl;
      if ($urandom_range(0, 1) == 1) begin
        rv = 1'($urandom_range(0, 1));
        req(kl, rv, 1'b1, rnd256());
        run(nr, rv, rnd, 1, $sformatf("rnd%0d replay", r));
      end
      if ($urandom_range(0, 3) == 0)
        expect_err(2'((int'(kl) + 1) % 3), 1'b0, 1'b1,
                   $sformatf("rnd%0d mismatch", r));
    end

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expect_err(last_kl, 1'b0, 1'b1, "replay after idle reset");

    kk = rnd256();
    model(2'd0, kk);
    req(2'd0, 1'b0, 1'b0, kk);
    rk_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (rk_valid && rk_idx == 4'd5) found = 1'b1;
      else @(negedge clk);
    end
    chk("reach idx5", 136'(found), 136'(1));
    chk("idx5 key", 136'(rk), 136'(mdl[5]));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rk_ready = 1'b0;
    chk("mid-stream reset", 136'({rk_valid, busy}), 136'(0));
    expect_err(2'd0, 1'b0, 1'b1, "replay after mid reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
